vec_reg_file_masked: RTL and testbench
======================================

VEC_REG_FILE_MASKED -- requirements
Module: vec_reg_file_masked

Interface
REQ-001 SHALL have parameter registerSize, default 16, bits per lane element.
REQ-002 SHALL have parameter registerQuantity, default 8, number of vector registers (power of two, >=2).
REQ-003 SHALL have parameter selectionBits, default 3, register-index width = log2(registerQuantity).
REQ-004 SHALL have parameter vectorSize, default 4, lanes per vector register.
REQ-005 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port regWrEn  input  1  write request.
REQ-008 SHALL have port regToWrite  input  selectionBits  write destination index.
REQ-009 SHALL have port laneMask  input  vectorSize  per-lane write enable; bit j gates lane j.
REQ-010 SHALL have port regWriteData  input  vectorSize x registerSize  write data, packed by lane.
REQ-011 SHALL have ports rSel1, rSel2  input  selectionBits  read indices.
REQ-012 SHALL have ports reg1Out, reg2Out  output  vectorSize x registerSize  read data.
REQ-013 SHALL have port issueEn  input  1  marks issueReg as pending a future write.
REQ-014 SHALL have port issueReg  input  selectionBits  issued destination index.
REQ-015 SHALL have port clearReq  input  1  request to zero every register.
REQ-016 SHALL have port busy  output  1  clear sequence in progress.
REQ-017 SHALL have port pending  output  registerQuantity  scoreboard bits.
REQ-018 SHALL have ports hazard1, hazard2  output  1  pending[rSel1], pending[rSel2].

Function
REQ-019 SHALL accept a write on a rising clk edge when regWrEn=1 and busy=0; only lanes with laneMask[j]=1 of register regToWrite update; other lanes and registers hold.
REQ-020 SHALL ignore regWrEn while busy=1 (write dropped, not queued).
REQ-021 SHALL drive reg1Out/reg2Out combinationally from rSel1/rSel2 (zero-cycle read latency).
REQ-022 SHALL bypass: when busy=0, regWrEn=1 and regToWrite equals a read index, masked lanes return regWriteData and unmasked lanes return stored value, same cycle.
REQ-023 SHALL NOT bypass while busy=1; reads return stored contents.
REQ-024 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on clearReq=1; CLEAR -> IDLE after the cycle clearing index registerQuantity-1.
REQ-025 SHALL, in CLEAR, zero all lanes of register clrIdx each cycle, clrIdx starting 0 and incrementing by 1; sequence lasts exactly registerQuantity cycles.
REQ-026 SHALL assert busy=1 exactly in CLEAR; clearReq in CLEAR ignored.
REQ-027 SHALL set pending[issueReg] on a rising edge with issueEn=1 and busy=0; issueEn while busy=1 ignored.
REQ-028 SHALL clear pending[regToWrite] on an accepted write, regardless of laneMask (including laneMask=0).
REQ-029 SHALL give set priority: simultaneous issue and accepted write to the same index leave pending=1.
REQ-030 SHALL clear all pending bits on the IDLE->CLEAR transition edge.
REQ-031 SHALL compute hazard1/hazard2 combinationally from registered pending (no bypass of same-cycle issue/write).

Reset
REQ-032 SHALL, on reset=1, asynchronously zero all register lanes, pending, clrIdx, and force IDLE; thus busy=0, hazards=0, read outputs=0.
REQ-033 SHALL abort an in-progress CLEAR on reset, returning to IDLE.

Structure
REQ-034 SHALL place FSM state enum (IDLE, CLEAR) and default parameter constants in shared package vec_reg_pkg.
REQ-035 SHALL instantiate registerQuantity copies of sub-module vec_lane_register (one vector register, per-lane enable, async reset, synchronous zero input).

Verification
REQ-036 SHALL test: reset, write reg2 = {4,3,2,1} mask 1111, read rSel1=2 -> {4,3,2,1}.
REQ-037 SHALL test: then write reg2 = {F,F,F,F} mask 0101 -> read {4,F,2,F}; same-cycle bypass shows {4,F,2,F} before edge.
REQ-038 SHALL test: issueEn reg5 -> pending=0x20, hazard2=1 with rSel2=5; then write reg5 mask 0000 -> pending=0, data unchanged.
REQ-039 SHALL test: issue and write reg3 same cycle -> pending[3]=1 afterwards.
REQ-040 SHALL test: fill all regs, clearReq -> busy high 8 cycles, writes during CLEAR dropped, all regs 0 and pending 0 after.
REQ-041 SHALL test: assert reset at CLEAR cycle 3 -> busy=0 immediately, all regs 0, next clearReq restarts at clrIdx 0.

Source files
------------

// File: rtl/vec_reg_pkg.sv
// Shared constants and FSM encoding for the masked vector register file.
package vec_reg_pkg;

    localparam int unsigned DEF_REGISTER_SIZE     = 16;
    localparam int unsigned DEF_REGISTER_QUANTITY = 8;
    localparam int unsigned DEF_SELECTION_BITS    = 3;
    localparam int unsigned DEF_VECTOR_SIZE       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/vec_reg_file_masked_if.sv
// Write/read/issue/clear bus of the masked vector register file.
interface vec_reg_file_masked_if
    import vec_reg_pkg::*;
#(
    parameter int unsigned registerSize     = DEF_REGISTER_SIZE,
    parameter int unsigned registerQuantity = DEF_REGISTER_QUANTITY,
    parameter int unsigned selectionBits    = DEF_SELECTION_BITS,
    parameter int unsigned vectorSize       = DEF_VECTOR_SIZE
) ();

    logic                               regWrEn;
    logic [selectionBits-1:0]           regToWrite;
    logic [vectorSize-1:0]              laneMask;
    logic [vectorSize*registerSize-1:0] regWriteData;
    logic [selectionBits-1:0]           rSel1;
    logic [selectionBits-1:0]           rSel2;
    logic [vectorSize*registerSize-1:0] reg1Out;
    logic [vectorSize*registerSize-1:0] reg2Out;
    logic                               issueEn;
    logic [selectionBits-1:0]           issueReg;
    logic                               clearReq;
    logic                               busy;
    logic [registerQuantity-1:0]        pending;
    logic                               hazard1;
    logic                               hazard2;

    modport master (
        output regWrEn, regToWrite, laneMask, regWriteData, rSel1, rSel2,
               issueEn, issueReg, clearReq,
        input  reg1Out, reg2Out, busy, pending, hazard1, hazard2
    );

    modport slave (
        input  regWrEn, regToWrite, laneMask, regWriteData, rSel1, rSel2,
               issueEn, issueReg, clearReq,
        output reg1Out, reg2Out, busy, pending, hazard1, hazard2
    );

endinterface

// File: rtl/vec_lane_register.sv
// One vector register: per-lane write enables, async reset, synchronous zero.
module vec_lane_register
    import vec_reg_pkg::*;
#(
    parameter int unsigned registerSize = DEF_REGISTER_SIZE,
    parameter int unsigned vectorSize   = DEF_VECTOR_SIZE
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [vectorSize-1:0]              laneEn,
    input  logic                               zero,
    input  logic [vectorSize*registerSize-1:0] wrData,
    output logic [vectorSize*registerSize-1:0] q
);

    logic [vectorSize*registerSize-1:0] data_q;
    logic [vectorSize*registerSize-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (zero) begin
            data_d = '0;
        end else begin
            for (int unsigned j = 0; j < vectorSize; j++) begin
                if (laneEn[j]) begin
                    data_d[j*registerSize +: registerSize] = wrData[j*registerSize +: registerSize];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/vec_reg_file_masked.sv
// Masked vector register file with write bypass, issue scoreboard and
// a sequential one-register-per-cycle clear sequence.
module vec_reg_file_masked
    import vec_reg_pkg::*;
#(
    parameter int unsigned registerSize     = DEF_REGISTER_SIZE,
    parameter int unsigned registerQuantity = DEF_REGISTER_QUANTITY,
    parameter int unsigned selectionBits    = DEF_SELECTION_BITS,
    parameter int unsigned vectorSize       = DEF_VECTOR_SIZE
) (
    input logic                  clk,
    input logic                  reset,
    vec_reg_file_masked_if.slave bus
);

    localparam int unsigned W = vectorSize * registerSize;
    localparam logic [selectionBits-1:0] LAST_IDX = selectionBits'(registerQuantity - 1);

    state_t                      state_q, state_d;
    logic [selectionBits-1:0]    clr_idx_q, clr_idx_d;
    logic [registerQuantity-1:0] pending_q, pending_d;
    logic                        busy_q, busy_d;

    logic         accept;
    logic [W-1:0] rf [registerQuantity];

    assign accept = bus.regWrEn && !busy_q;

    for (genvar i = 0; i < registerQuantity; i++) begin : g_reg
        vec_lane_register #(
            .registerSize(registerSize),
            .vectorSize  (vectorSize)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .laneEn((accept && bus.regToWrite == selectionBits'(i)) ? bus.laneMask : '0),
            .zero  (busy_q && clr_idx_q == selectionBits'(i)),
            .wrData(bus.regWriteData),
            .q     (rf[i])
        );
    end

    // Issue is applied after the write-clear so a same-index collision leaves the bit set.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.clearReq) begin
                    state_d   = CLEAR;
                    busy_d    = 1'b1;
                    clr_idx_d = '0;
                    pending_d = '0;
                end else begin
                    if (accept)      pending_d[bus.regToWrite] = 1'b0;
                    if (bus.issueEn) pending_d[bus.issueReg]   = 1'b1;
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        bus.reg1Out = rf[bus.rSel1];
        bus.reg2Out = rf[bus.rSel2];
        for (int unsigned j = 0; j < vectorSize; j++) begin
            if (accept && bus.laneMask[j]) begin
                if (bus.regToWrite == bus.rSel1)
                    bus.reg1Out[j*registerSize +: registerSize] = bus.regWriteData[j*registerSize +: registerSize];
                if (bus.regToWrite == bus.rSel2)
                    bus.reg2Out[j*registerSize +: registerSize] = bus.regWriteData[j*registerSize +: registerSize];
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.pending = pending_q;
    assign bus.hazard1 = pending_q[bus.rSel1];
    assign bus.hazard2 = pending_q[bus.rSel2];

endmodule

// File: tb/tb_vec_reg_file_masked.sv
// Directed self-checking bench for vec_reg_file_masked (default parameters).
module tb_vec_reg_file_masked;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vec_reg_file_masked_if #(
        .registerSize    (16),
        .registerQuantity(8),
        .selectionBits   (3),
        .vectorSize      (4)
    ) bus ();

    vec_reg_file_masked #(
        .registerSize    (16),
        .registerQuantity(8),
        .selectionBits   (3),
        .vectorSize      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [3:0] mask, input logic [63:0] data);
        bus.regWrEn      = 1'b1;
        bus.regToWrite   = idx;
        bus.laneMask     = mask;
        bus.regWriteData = data;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 4'hF, {4{16'(i + 1)}});
            tick();
        end
        bus.regWrEn = 1'b0;
    endtask

    initial begin
        bus.regWrEn = 1'b0; bus.regToWrite = '0; bus.laneMask = '0; bus.regWriteData = '0;
        bus.rSel1 = '0; bus.rSel2 = '0; bus.issueEn = 1'b0; bus.issueReg = '0; bus.clearReq = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pending", 64'(bus.pending), 64'h00);
        check("rst_reg1", bus.reg1Out, 64'h0);
        check("rst_haz", {62'd0, bus.hazard1, bus.hazard2}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Full-mask write of reg2, visible via bypass then via storage
        bus.rSel1 = 3'd2; bus.rSel2 = 3'd3;
        wr(3'd2, 4'b1111, 64'h0004_0003_0002_0001);
        #1 check("byp_full", bus.reg1Out, 64'h0004_0003_0002_0001);
        tick();
        bus.regWrEn = 1'b0;
        #1 check("rd_full", bus.reg1Out, 64'h0004_0003_0002_0001);

        // Partial mask 0101: lanes 0 and 2 take F
        wr(3'd2, 4'b0101, 64'h000F_000F_000F_000F);
        #1 check("byp_mask", bus.reg1Out, 64'h0004_000F_0002_000F);
        check("byp_other", bus.reg2Out, 64'h0);
        tick();
        bus.regWrEn = 1'b0;
        #1 check("rd_mask", bus.reg1Out, 64'h0004_000F_0002_000F);

        // Scoreboard: issue reg5, hazard only from registered state
        bus.rSel2 = 3'd5; bus.issueEn = 1'b1; bus.issueReg = 3'd5;
        #1 check("haz_nobyp", 64'(bus.hazard2), 64'd0);
        tick();
        bus.issueEn = 1'b0;
        #1 check("iss_pending", 64'(bus.pending), 64'h20);
        check("iss_haz2", 64'(bus.hazard2), 64'd1);
        check("iss_haz1", 64'(bus.hazard1), 64'd0);
        wr(3'd5, 4'b0000, 64'h1234_5678_9ABC_DEF0);
        tick();
        bus.regWrEn = 1'b0;
        #1 check("wr0_pending", 64'(bus.pending), 64'h00);
        check("wr0_data", bus.reg2Out, 64'h0);

        // Same-cycle issue and write to reg3: set wins
        bus.rSel2 = 3'd3;
        wr(3'd3, 4'hF, 64'hAAAA_BBBB_CCCC_DDDD);
        bus.issueEn = 1'b1; bus.issueReg = 3'd3;
        tick();
        bus.regWrEn = 1'b0; bus.issueEn = 1'b0;
        #1 check("prio_pending", 64'(bus.pending), 64'h08);
        check("prio_data", bus.reg2Out, 64'hAAAA_BBBB_CCCC_DDDD);

        // Full clear sequence with writes and issues attempted throughout
        fill_all();
        bus.rSel1 = 3'd0;
        bus.clearReq = 1'b1;
        tick();
        bus.clearReq = 1'b0;
        wr(3'd0, 4'hF, 64'h5555_5555_5555_5555);
        bus.issueEn = 1'b1; bus.issueReg = 3'd6;
        for (int k = 0; k < 8; k++) begin
            bus.clearReq = (k == 3);
            #1 check($sformatf("clr_busy%0d", k), 64'(bus.busy), 64'd1);
            check($sformatf("clr_nobyp%0d", k), bus.reg1Out, (k == 0) ? {4{16'd1}} : 64'h0);
            tick();
        end
        bus.clearReq = 1'b0; bus.regWrEn = 1'b0; bus.issueEn = 1'b0;
        #1 check("clr_done_busy", 64'(bus.busy), 64'd0);
        check("clr_done_pend", 64'(bus.pending), 64'h00);
        for (int i = 0; i < 8; i++) begin
            bus.rSel1 = 3'(i);
            #1 check($sformatf("clr_reg%0d", i), bus.reg1Out, 64'h0);
        end

        // Reset aborts a clear at clrIdx 3
        fill_all();
        bus.issueEn = 1'b1; bus.issueReg = 3'd4;
        tick();
        bus.issueEn = 1'b0;
        bus.clearReq = 1'b1;
        tick();
        bus.clearReq = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        bus.rSel1 = 3'd7; bus.rSel2 = 3'd3;
        #1 check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_reg7", bus.reg1Out, 64'h0);
        check("abort_reg3", bus.reg2Out, 64'h0);
        check("abort_pend", 64'(bus.pending), 64'h00);
        #1 reset = 1'b0;
        tick();

        // Restarted clear must begin at index 0
        wr(3'd0, 4'hF, 64'h1111_1111_1111_1111); tick();
        wr(3'd1, 4'hF, 64'h2222_2222_2222_2222); tick();
        bus.regWrEn = 1'b0;
        bus.rSel1 = 3'd0; bus.rSel2 = 3'd1;
        bus.clearReq = 1'b1;
        tick();
        bus.clearReq = 1'b0;
        tick();
        check("restart_reg0", bus.reg1Out, 64'h0);
        check("restart_reg1", bus.reg2Out, 64'h2222_2222_2222_2222);
        for (int k = 0; k < 7; k++) tick();
        check("restart_busy", 64'(bus.busy), 64'd0);
        check("restart_reg1z", bus.reg2Out, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
